// File: rtl/fsm_input_conditioner_if.sv
// Raw X/Y inputs and conditioned outputs of fsm_input_conditioner.
// The master side drives the raw inputs; the conditioner is the slave.
interface fsm_input_conditioner_if #(
   parameter int GLT_W = 8
);
   logic             x_raw;
   logic             y_raw;
   logic             X;
   logic             Y;
   logic             busy;
   logic [GLT_W-1:0] glitch_cnt;

   modport master (
      output x_raw, y_raw,
      input  X, Y, busy, glitch_cnt
   );

   modport slave (
      input  x_raw, y_raw,
      output X, Y, busy, glitch_cnt
   );
endinterface

// File: rtl/fsm_input_conditioner.sv
// Synchronizes and debounces raw X/Y into clk-domain drives for the control FSM.
// Optional build macro INCOND_PULSE_EN turns X/Y into one-cycle press pulses.
module fsm_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 4,
   parameter int CNT_W       = 4,
   parameter int GLT_W       = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   fsm_input_conditioner_if.slave  bus
);

   typedef enum logic [1:0] {STABLE0, WAIT1, STABLE1, WAIT0} deb_state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0] raw;
   logic [1:0] out_lvl;
   logic [1:0] wait_st;
   logic [1:0] rej;
   logic [GLT_W-1:0] glt;

   function automatic logic [GLT_W-1:0] sat_add(input logic [GLT_W-1:0] a,
                                                input logic [1:0]       inc);
      logic [GLT_W:0] sum;
      sum = {1'b0, a} + {{(GLT_W-1){1'b0}}, inc};
      return sum[GLT_W] ? {GLT_W{1'b1}} : sum[GLT_W-1:0];
   endfunction

   assign raw = {bus.y_raw, bus.x_raw};

   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync;
      logic                   s;
      deb_state_t             state;
      logic [CNT_W-1:0]       cnt;
      logic                   out_q;

      assign s = sync[SYNC_STAGES-1];

      // out_q follows the debounced level, or pulses once per accepted rise
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync  <= '0;
            state <= STABLE0;
            cnt   <= '0;
            out_q <= 1'b0;
         end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw[ch]};
`ifdef INCOND_PULSE_EN
            out_q <= 1'b0;
`endif
            case (state)
               STABLE0: if (s) begin
                  if (DEB_CYCLES == 1) begin
                     state <= STABLE1;
                     out_q <= 1'b1;
                  end else begin
                     state <= WAIT1;
                     cnt   <= CNT_W'(1);
                  end
               end
               WAIT1: if (!s) begin
                  state <= STABLE0;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= STABLE1;
                  cnt   <= '0;
                  out_q <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
               STABLE1: if (!s) begin
                  if (DEB_CYCLES == 1) begin
                     state <= STABLE0;
`ifndef INCOND_PULSE_EN
                     out_q <= 1'b0;
`endif
                  end else begin
                     state <= WAIT0;
                     cnt   <= CNT_W'(1);
                  end
               end
               WAIT0: if (s) begin
                  state <= STABLE1;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= STABLE0;
                  cnt   <= '0;
`ifndef INCOND_PULSE_EN
                  out_q <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
               default: state <= STABLE0;
            endcase
         end
      end

      assign out_lvl[ch] = out_q;
      assign wait_st[ch] = (state == WAIT1) || (state == WAIT0);
      assign rej[ch]     = ((state == WAIT1) && !s) || ((state == WAIT0) && s);
   end

   // Both channels may reject on the same edge, so the increment is 0..2
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         glt <= '0;
      end else begin
         glt <= sat_add(glt, {1'b0, rej[0]} + {1'b0, rej[1]});
      end
   end

   assign bus.X          = out_lvl[0];
   assign bus.Y          = out_lvl[1];
   assign bus.busy       = |wait_st;
   assign bus.glitch_cnt = glt;

endmodule
